// File: rtl/vga_pkg.sv
// Shared constants and FSM encoding for the framebuffer arbiter.
// Screen geometry sets the per-line burst length.
package vga_pkg;

    localparam int SCREEN_WIDTH  = 800;
    localparam int SCREEN_HEIGHT = 600;
    localparam int PIX_PER_WORD  = 8;
    localparam int LINE_WORDS    = SCREEN_WIDTH / PIX_PER_WORD;
    localparam int ADDR_W        = 16;
    localparam int DATA_W        = 8;
    localparam int LB_AW         = 7;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } fb_state_t;

endpackage

// File: rtl/vga_fb_addr_gen.sv
// Line base and word counter for scanline bursts.
// Produces the RAM fetch address and a last-word flag.
module vga_fb_addr_gen #(
    parameter int LINE_WORDS = vga_pkg::LINE_WORDS,
    parameter int ADDR_W     = vga_pkg::ADDR_W,
    parameter int LB_AW      = vga_pkg::LB_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [10:0]       line_num,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic [LB_AW-1:0]  wcnt,
    output logic              last
);

    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] base_nxt;

    assign base_nxt = ADDR_W'(32'(line_num) * 32'(LINE_WORDS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base <= '0;
            wcnt <= '0;
        end else if (start) begin
            base <= base_nxt;
            wcnt <= '0;
        end else if (advance) begin
            wcnt <= wcnt + 1'b1;
        end
    end

    assign addr = base + ADDR_W'(wcnt);
    assign last = (wcnt == LB_AW'(LINE_WORDS - 1));

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: scanline refill bursts
// take strict priority over single-word draw writes.
module vga_fb_arbiter #(
    parameter int LINE_WORDS   = vga_pkg::LINE_WORDS,
    parameter int SCREEN_LINES = vga_pkg::SCREEN_HEIGHT,
    parameter int ADDR_W       = vga_pkg::ADDR_W,
    parameter int DATA_W       = vga_pkg::DATA_W,
    parameter int LB_AW        = vga_pkg::LB_AW
) (
    input  logic              clk,
    input  logic              w_rst_n,
    input  logic              line_req,
    input  logic [10:0]       line_num,
    output logic              line_busy,
    output logic              line_err,
    output logic              ln_we,
    output logic [LB_AW-1:0]  ln_addr,
    output logic [DATA_W-1:0] ln_data,
    input  logic              drw_req,
    input  logic [ADDR_W-1:0] drw_addr,
    input  logic [DATA_W-1:0] drw_data,
    output logic              drw_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    import vga_pkg::*;

    fb_state_t         state;
    fb_state_t         state_nxt;
    logic              start;
    logic              advance;
    logic              last;
    logic              line_ok;
    logic [ADDR_W-1:0] fetch_addr;
    logic [LB_AW-1:0]  wcnt;

    assign line_ok = (32'(line_num) < 32'(SCREEN_LINES));

    vga_fb_addr_gen #(
        .LINE_WORDS (LINE_WORDS),
        .ADDR_W     (ADDR_W),
        .LB_AW      (LB_AW)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (w_rst_n),
        .start    (start),
        .line_num (line_num),
        .advance  (advance),
        .addr     (fetch_addr),
        .wcnt     (wcnt),
        .last     (last)
    );

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        advance   = 1'b0;
        drw_ack   = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state)
            IDLE: begin
                if (line_req) begin
                    if (line_ok) begin
                        start     = 1'b1;
                        state_nxt = FETCH;
                    end
                end else if (drw_req) begin
                    drw_ack   = 1'b1;
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = drw_addr;
                    mem_wdata = drw_data;
                end
            end
            FETCH: begin
                mem_en   = 1'b1;
                mem_addr = fetch_addr;
                advance  = 1'b1;
                if (last) state_nxt = DRAIN;
            end
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // busy stays up one cycle past DRAIN so the last line-buffer write is covered
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state     <= IDLE;
            line_busy <= 1'b0;
            line_err  <= 1'b0;
            ln_we     <= 1'b0;
            ln_addr   <= '0;
        end else begin
            state     <= state_nxt;
            line_busy <= (state_nxt != IDLE) || (state == DRAIN);
            line_err  <= line_req && ((state != IDLE) || !line_ok);
            ln_we     <= (state == FETCH);
            if (state == FETCH) ln_addr <= wcnt;
        end
    end

    // read data arrives in the cycle ln_we is high; forward it directly
    assign ln_data = ln_we ? mem_rdata : '0;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural sync RAM.
module tb_vga_fb_arbiter;

    logic        clk = 1'b0;
    logic        w_rst_n;
    logic        line_req;
    logic [10:0] line_num;
    logic        line_busy, line_err, ln_we;
    logic [6:0]  ln_addr;
    logic [7:0]  ln_data;
    logic        drw_req;
    logic [15:0] drw_addr;
    logic [7:0]  drw_data;
    logic        drw_ack, mem_en, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    logic        ram_init;
    logic [7:0]  ram [65536];
    logic [7:0]  ovr [int];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    vga_fb_arbiter dut (
        .clk(clk), .w_rst_n(w_rst_n),
        .line_req(line_req), .line_num(line_num),
        .line_busy(line_busy), .line_err(line_err),
        .ln_we(ln_we), .ln_addr(ln_addr), .ln_data(ln_data),
        .drw_req(drw_req), .drw_addr(drw_addr), .drw_data(drw_data),
        .drw_ack(drw_ack), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 65536; i++) ram[i] <= 8'(i);
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else mem_rdata <= ram[mem_addr];
        end
    end

    typedef struct {
        logic        lr;
        logic [10:0] ln;
        logic        dr;
        logic [15:0] da;
        logic [7:0]  dd;
        logic        ack;
        logic        en;
        logic        we;
        logic [15:0] ea;
        logic [7:0]  ew;
        logic        err;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_data(input int a);
        return ovr.exists(a) ? ovr[a] : 8'(a);
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(line_busy), 32'(0));
        chk({tag, "_err"}, 32'(line_err), 32'(0));
        chk({tag, "_ln_we"}, 32'(ln_we), 32'(0));
        chk({tag, "_ln_addr"}, 32'(ln_addr), 32'(0));
        chk({tag, "_ln_data"}, 32'(ln_data), 32'(0));
        chk({tag, "_ack"}, 32'(drw_ack), 32'(0));
        chk({tag, "_mem_en"}, 32'(mem_en), 32'(0));
        chk({tag, "_mem_we"}, 32'(mem_we), 32'(0));
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(0));
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(0));
    endtask

    // cycle 0 = line_req cycle; called at the start of a cycle
    task automatic burst(input int ln, input int bad_at, input bit draw);
        int base;
        int maxa;
        bit rd, lw, ack;
        base = ln * 100;
        maxa = 0;
        line_req = 1'b1;
        line_num = 11'(ln);
        if (draw) begin
            drw_req  = 1'b1;
            drw_addr = 16'h1234;
            drw_data = 8'hA5;
        end
        for (int c = 0; c <= 104; c++) begin
            @(negedge clk);
            rd  = (c >= 1 && c <= 100);
            lw  = (c >= 2 && c <= 101);
            ack = draw && (c == 102);
            chk("mem_en", 32'(mem_en), 32'(rd || ack));
            chk("mem_we", 32'(mem_we), 32'(ack));
            if (rd) chk("rd_addr", 32'(mem_addr), 32'(base + c - 1));
            if (ack) begin
                chk("drw_addr", 32'(mem_addr), 32'h1234);
                chk("drw_wdata", 32'(mem_wdata), 32'hA5);
                ovr[32'h1234] = 8'hA5;
            end
            if (mem_en && !mem_we && int'(mem_addr) > maxa) maxa = int'(mem_addr);
            chk("ln_we", 32'(ln_we), 32'(lw));
            if (lw) begin
                chk("ln_addr", 32'(ln_addr), 32'(c - 2));
                chk("ln_data", 32'(ln_data), 32'(exp_data(base + c - 2)));
            end
            chk("line_busy", 32'(line_busy), 32'(c >= 1 && c <= 102));
            chk("drw_ack", 32'(drw_ack), 32'(ack));
            chk("line_err", 32'(line_err), 32'(bad_at > 0 && c == bad_at + 1));
            @(posedge clk);
            #1;
            line_req = (bad_at > 0 && c + 1 == bad_at);
            line_num = 11'd5;
            if (ack) drw_req = 1'b0;
        end
        chk("max_rd_addr", 32'(maxa), 32'(base + 99));
    endtask

    initial begin
        tbl[0] = '{1'b0, 11'd0,    1'b0, 16'h0000, 8'h00,
                   1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0};
        tbl[1] = '{1'b0, 11'd0,    1'b1, 16'h8000, 8'h11,
                   1'b1, 1'b1, 1'b1, 16'h8000, 8'h11, 1'b0};
        tbl[2] = '{1'b1, 11'd600,  1'b0, 16'h0000, 8'h00,
                   1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1};
        tbl[3] = '{1'b1, 11'd2047, 1'b0, 16'h0000, 8'h00,
                   1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1};
        tbl[4] = '{1'b1, 11'd600,  1'b1, 16'h8001, 8'h22,
                   1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1};
        tbl[5] = '{1'b0, 11'd0,    1'b1, 16'hFFFF, 8'h5A,
                   1'b1, 1'b1, 1'b1, 16'hFFFF, 8'h5A, 1'b0};

        w_rst_n  = 1'b0;
        ram_init = 1'b1;
        line_req = 1'b0;
        line_num = '0;
        drw_req  = 1'b0;
        drw_addr = '0;
        drw_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        ram_init = 1'b0;
        w_rst_n  = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            line_req = tbl[i].lr;
            line_num = tbl[i].ln;
            drw_req  = tbl[i].dr;
            drw_addr = tbl[i].da;
            drw_data = tbl[i].dd;
            @(negedge clk);
            chk($sformatf("v%0d_ack", i), 32'(drw_ack), 32'(tbl[i].ack));
            chk($sformatf("v%0d_en", i), 32'(mem_en), 32'(tbl[i].en));
            chk($sformatf("v%0d_we", i), 32'(mem_we), 32'(tbl[i].we));
            if (tbl[i].en) begin
                chk($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(tbl[i].ea));
                chk($sformatf("v%0d_wdata", i), 32'(mem_wdata), 32'(tbl[i].ew));
            end
            @(posedge clk);
            #1;
            line_req = 1'b0;
            drw_req  = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_err", i), 32'(line_err), 32'(tbl[i].err));
            chk($sformatf("v%0d_busy", i), 32'(line_busy), 32'(0));
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < 10; i++) begin
            drw_req  = 1'b1;
            drw_addr = 16'(16'h9000 + i);
            drw_data = 8'(i * 3);
            @(negedge clk);
            chk($sformatf("strm%0d_ack", i), 32'(drw_ack), 32'(1));
            chk($sformatf("strm%0d_we", i), 32'(mem_we), 32'(1));
            chk($sformatf("strm%0d_addr", i), 32'(mem_addr), 32'h9000 + 32'(i));
            chk($sformatf("strm%0d_wdata", i), 32'(mem_wdata), 32'(i * 3));
            @(posedge clk);
            #1;
        end
        drw_req = 1'b0;

        burst(0, 0, 1'b0);
        burst(599, 0, 1'b0);
        burst(10, 50, 1'b0);
        burst(20, 0, 1'b1);
        burst(46, 0, 1'b0);

        line_req = 1'b1;
        line_num = 11'd3;
        @(posedge clk);
        #1;
        line_req = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("rst_word40_addr", 32'(mem_addr), 32'(340));
        chk("rst_word40_lnwe", 32'(ln_we), 32'(1));
        #1;
        w_rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        @(posedge clk);
        #1;
        chk("midrst_hold_lnwe", 32'(ln_we), 32'(0));
        chk("midrst_hold_en", 32'(mem_en), 32'(0));
        @(negedge clk);
        w_rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_busy", 32'(line_busy), 32'(0));
        chk("post_rst_en", 32'(mem_en), 32'(0));
        chk("post_rst_lnwe", 32'(ln_we), 32'(0));
        burst(7, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Sits between the SVGA sync/timing block and a single-port synchronous framebuffer RAM.
- Per scanline: on a request from the timing side, bursts one line of pixel words from the RAM into the scanout line buffer.
- Between bursts: grants single-word writes from the drawing (game) logic.
- Display refill has strict priority over draw writes; the block guarantees the line buffer is filled within LINE_WORDS+2 cycles of the request.

Parameters:
- LINE_WORDS, 100, framebuffer words per scanline (800 px / 8 px per word)
- SCREEN_LINES, 600, number of valid line indices
- ADDR_W, 16, framebuffer word address width (must hold SCREEN_LINES*LINE_WORDS-1)
- DATA_W, 8, framebuffer word width
- LB_AW, 7, line-buffer address width (2**LB_AW >= LINE_WORDS)

Ports:
- clk  in  1  system/pixel clock
- w_rst_n  in  1  asynchronous active-low reset
- line_req  in  1  one-cycle pulse: fetch line line_num
- line_num  in  11  scanline index to fetch
- line_busy  out  1  burst in progress
- line_err  out  1  one-cycle pulse: request rejected (busy or line_num out of range)
- ln_we  out  1  line-buffer write strobe
- ln_addr  out  LB_AW  line-buffer word address
- ln_data  out  DATA_W  line-buffer write data
- drw_req  in  1  draw write request, held until drw_ack
- drw_addr  in  ADDR_W  draw word address
- drw_data  in  DATA_W  draw word data
- drw_ack  out  1  one-cycle pulse: write issued this cycle
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid exactly 1 cycle after mem_en && !mem_we

Behaviour:
- Reset (async assert, sync release): state=IDLE; line_busy, line_err, ln_we, drw_ack, mem_en, mem_we = 0; ln_addr, ln_data, mem_addr, mem_wdata = 0; word counter and line base = 0.
- States: IDLE, FETCH, DRAIN.
- IDLE, line_req with line_num < SCREEN_LINES:
  - latch base = line_num*LINE_WORDS (single multiply, truncated to ADDR_W); word counter wcnt=0.
  - go FETCH; line_busy=1 from the next cycle.
- IDLE, line_req with line_num >= SCREEN_LINES: line_err=1 for one cycle; stay IDLE; no RAM access.
- FETCH:
  - each cycle: mem_en=1, mem_we=0, mem_addr=base+wcnt; wcnt increments.
  - when wcnt==LINE_WORDS-1 is issued, go DRAIN.
- Read returns: one cycle after each read, ln_we=1, ln_addr=index of that read, ln_data=mem_rdata (registered outputs, so ln_* lags the mem_addr issue by 1 cycle).
- DRAIN: no RAM access; the last ln_we occurs; return to IDLE; line_busy drops the cycle after DRAIN.
- Latency: request at cycle 0 gives mem reads at cycles 1..LINE_WORDS and ln_we at cycles 2..LINE_WORDS+1.
- line_req while line_busy (FETCH or DRAIN): ignored; line_err pulses; burst continues unaffected.
- Draw path:
  - only in IDLE with no line_req that cycle: mem_en=1, mem_we=1, mem_addr=drw_addr, mem_wdata=drw_data; drw_ack=1 in the same cycle (combinational from state and drw_req).
  - Requester drops or updates drw_req after the ack cycle; back-to-back acks allowed every cycle.
- Simultaneous line_req and drw_req in IDLE: line wins; drw_ack=0; draw is served after DRAIN.
- drw_req during FETCH/DRAIN: held off; drw_ack=0.
- mem_en=0 in IDLE with no request; mem_we=0 whenever mem_en=0.
- Reset mid-burst: everything returns to reset values immediately; a partially filled line buffer is left as is; no ln_we after reset assertion.

Decomposition:
- Shared package vga_pkg: SCREEN_WIDTH/HEIGHT constants, LINE_WORDS, ADDR_W/DATA_W, FSM state encoding typedef (IDLE/FETCH/DRAIN).
- Optional sub-module vga_fb_addr_gen: holds base and wcnt, outputs the fetch address and last-word flag. Everything else stays in vga_fb_arbiter.

Test Plan:
- Line 0 fetch:
  - stimulus: RAM preloaded with addr[7:0]; line_req, line_num=0.
  - required: mem_addr 0..99 on cycles 1..100; ln_we on cycles 2..101 with ln_addr 0..99 and ln_data 0x00..0x63; line_busy high for cycles 1..102.
- Last line:
  - stimulus: line_num=599.
  - required: mem_addr 59900..59999; no address beyond 59999.
- Bad requests:
  - stimulus: line_num=600 in IDLE.
  - required: line_err pulse, no mem_en.
  - stimulus: line_req at cycle 50 of a burst.
  - required: line_err pulse; original burst completes unchanged.
- Contention:
  - stimulus: drw_req (addr 0x1234, data 0xA5) asserted together with line_req.
  - required: no ack until IDLE; ack on the first IDLE cycle; mem_we=1, mem_addr=0x1234, mem_wdata=0xA5 that cycle.
  - follow-up: a subsequent line fetch returns 0xA5 at the matching word.
- Draw streaming:
  - stimulus: 10 back-to-back draw writes in IDLE.
  - required: 10 consecutive acks, one per cycle, with addresses matching.
- Reset mid-burst:
  - stimulus: deassert w_rst_n at word 40.
  - required: all outputs 0 in the same cycle, state IDLE after release.
  - follow-up: a new line_req then fetches normally.
